// File: rtl/conv_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_frame_sequencer
// Purpose  : Frame controller for the 4-lane convolution datapath. Feeds one
//            frame of pixel beats into the convolution circuit, pads it with
//            zero flush beats, then trims the result stream so downstream
//            sees exactly one result beat per input beat.
// Revision : 1.0 - initial release
// ============================================================================
module conv_frame_sequencer #(
  parameter int DW          = 32,
  parameter int CW          = 16,
  parameter int FLUSH_BEATS = 2,
  parameter int DROP_BEATS  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] frame_beats,
  output logic          busy,
  output logic          done,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          c_valid,
  input  logic          c_ready,
  output logic [DW-1:0] c_data,
  input  logic          r_valid,
  output logic          r_ready,
  input  logic [DW-1:0] r_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_FEED  = 2'd1;
  localparam logic [1:0] c_ST_FLUSH = 2'd2;
  localparam logic [1:0] c_ST_WAIT  = 2'd3;

  // With no flush beats configured the frame goes straight to draining.
  localparam logic [1:0]  c_ST_AFTER_FEED = (FLUSH_BEATS == 0) ? c_ST_WAIT : c_ST_FLUSH;
  localparam logic [7:0]  c_FLUSH_LAST    = (FLUSH_BEATS > 0) ? 8'(FLUSH_BEATS - 1) : 8'd0;
  localparam logic [CW:0] c_FLUSH_EXT     = (CW+1)'(FLUSH_BEATS);
  localparam logic [CW:0] c_DROP_EXT      = (CW+1)'(DROP_BEATS);
  localparam logic [CW-1:0] c_ONE_N       = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]   c_ONE_R       = {{CW{1'b0}}, 1'b1};

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] r_n;
  logic [CW-1:0] r_in_cnt;
  logic [7:0]    r_fl_cnt;
  logic [CW:0]   r_r_cnt;
  logic          r_busy;
  logic          r_done;

  logic          w_c_hs;
  logic          w_r_hs;
  logic          w_start_frame;
  logic          w_start_empty;
  logic [CW:0]   w_n_ext;
  logic [CW:0]   w_total;
  logic [CW:0]   w_win_end;
  logic [CW:0]   w_last_k;
  logic [CW:0]   w_r_cnt_nxt;
  logic          w_in_win;

  assign w_c_hs        = c_valid && c_ready;
  assign w_r_hs        = r_valid && r_ready;
  assign w_start_frame = start && (frame_beats != '0);
  assign w_start_empty = start && (frame_beats == '0);
  assign w_n_ext       = {1'b0, r_n};
  // Total results to collect, and the [DROP, DROP+N) window that is delivered.
  assign w_total       = w_n_ext + c_FLUSH_EXT;
  assign w_win_end     = w_n_ext + c_DROP_EXT;
  assign w_last_k      = w_win_end - c_ONE_R;
  assign w_r_cnt_nxt   = w_r_hs ? (r_r_cnt + c_ONE_R) : r_r_cnt;
  assign w_in_win      = (r_r_cnt >= c_DROP_EXT) && (r_r_cnt < w_win_end);

  assign busy = r_busy;
  assign done = r_done;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; WAIT exits on the final result handshake itself so
  // done lands in the very next cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_start_frame) w_state_nxt = c_ST_FEED;
      end
      c_ST_FEED: begin
        if (w_c_hs && (r_in_cnt == (r_n - c_ONE_N))) w_state_nxt = c_ST_AFTER_FEED;
      end
      c_ST_FLUSH: begin
        if (w_c_hs && (r_fl_cnt == c_FLUSH_LAST)) w_state_nxt = c_ST_WAIT;
      end
      c_ST_WAIT: begin
        if (w_r_cnt_nxt >= w_total) w_state_nxt = c_ST_IDLE;
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Frame length latch and input/flush/result beat counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n      <= '0;
      r_in_cnt <= '0;
      r_fl_cnt <= '0;
      r_r_cnt  <= '0;
    end else if (r_state == c_ST_IDLE) begin
      if (w_start_frame) begin
        r_n      <= frame_beats;
        r_in_cnt <= '0;
        r_fl_cnt <= '0;
        r_r_cnt  <= '0;
      end
    end else begin
      if (w_c_hs && (r_state == c_ST_FEED))  r_in_cnt <= r_in_cnt + c_ONE_N;
      if (w_c_hs && (r_state == c_ST_FLUSH)) r_fl_cnt <= r_fl_cnt + 8'd1;
      if (w_r_hs) r_r_cnt <= r_r_cnt + c_ONE_R;
    end
  end

  // Registered busy flag and single-cycle completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != c_ST_IDLE);
      r_done <= ((r_state == c_ST_WAIT) && (w_state_nxt == c_ST_IDLE)) ||
                ((r_state == c_ST_IDLE) && w_start_empty);
    end
  end

  // Stream steering: pass-through or zero injection on the input side,
  // drop-or-deliver on the result side.
  always_comb begin
    s_ready = 1'b0;
    c_valid = 1'b0;
    c_data  = '0;
    r_ready = 1'b1;
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    case (r_state)
      c_ST_FEED: begin
        c_valid = s_valid;
        c_data  = s_data;
        s_ready = c_ready;
      end
      c_ST_FLUSH: begin
        c_valid = 1'b1;
      end
      default: begin
      end
    endcase
    if ((r_state != c_ST_IDLE) && w_in_win) begin
      m_valid = r_valid;
      m_data  = r_data;
      r_ready = m_ready;
      m_last  = r_valid && (r_r_cnt == w_last_k);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_frame_sequencer
// Purpose  : Scoreboard bench for conv_frame_sequencer with a 2-deep echo
//            model of the convolution circuit and randomized handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_frame_sequencer;

  localparam int FL = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] frame_beats;
  logic        busy, done;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic        c_valid, c_ready;
  logic [31:0] c_data;
  logic        r_valid, r_ready;
  logic [31:0] r_data;
  logic        m_valid, m_ready, m_last;
  logic [31:0] m_data;

  conv_frame_sequencer #(.DW(32), .CW(16), .FLUSH_BEATS(FL), .DROP_BEATS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_beats(frame_beats),
    .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: source pixels, convolution pipe, expected result beats.
  logic [31:0] src_q[$];
  logic [31:0] conv_q[$];
  logic [32:0] exp_q[$];
  logic [31:0] nxt_pix[$];
  logic [31:0] exp_c[$];
  logic [31:0] c_log[$];
  int  cyc = 0, last_r_cyc = 0, fr_r_cnt = 0, fr_s_cnt = 0;
  int  cur_n = 0, m_cnt = 0, m_start = 0;
  int  done_cnt = 0, exp_done_cnt = 0;
  bit  rnd = 0, got_done = 0, chk_busy_next = 0, exp_busy_next = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic reset_conv();
    conv_q.delete();
    conv_q.push_back(32'hBAD0_0001);
    conv_q.push_back(32'hBAD0_0002);
  endtask

  // Queue up one frame: its pixels as source data, and the same pixels as the
  // result stream downstream must see, tagged last on the final one.
  task automatic begin_frame(input int n, input bit seq);
    logic [31:0] p;
    nxt_pix.delete();
    for (int i = 0; i < n; i++) begin
      p = seq ? 32'(i + 1) : $urandom;
      nxt_pix.push_back(p);
      src_q.push_back(p);
      exp_q.push_back({(i == n - 1), p});
    end
  endtask

  // One clock: frame-completion checks, input drive, then handshake bookkeeping.
  task automatic tick(input bit st, input logic [15:0] fb, input bit auto_st, input bit rs);
    bit dn, bz, acc;
    @(negedge clk);
    cyc++;
    dn = done;
    bz = busy;
    got_done = dn;
    if (chk_busy_next) begin
      chk("busy_after_start", busy, exp_busy_next);
      chk_busy_next = 0;
    end
    if (dn) begin
      done_cnt++;
      chk("busy_in_done_cycle", bz, 0);
      if (cur_n != 0) begin
        chk("done_latency", cyc - last_r_cyc, 1);
        chk("r_beats_per_frame", fr_r_cnt, cur_n + FL);
        chk("m_beats_per_frame", m_cnt - m_start, cur_n);
        chk("c_beats_per_frame", c_log.size(), exp_c.size());
        for (int i = 0; i < c_log.size() && i < exp_c.size(); i++)
          if (c_log[i] !== exp_c[i]) chk("c_data", c_log[i], exp_c[i]);
      end else begin
        chk("zero_frame_c_beats", c_log.size(), 0);
      end
    end
    rst         = rs;
    start       = st | (auto_st & dn);
    frame_beats = fb;
    s_valid = (src_q.size() > 0) && (!rnd || ($urandom_range(0, 3) != 0));
    s_data  = (src_q.size() > 0) ? src_q[0] : $urandom;
    c_ready = !rnd || ($urandom_range(0, 3) != 0);
    r_valid = (conv_q.size() > 2) && (!rnd || ($urandom_range(0, 3) != 0));
    r_data  = conv_q[0];
    m_ready = !rnd || ($urandom_range(0, 2) != 0);
    if (rs) begin
      s_valid = 0;
      r_valid = 0;
      m_ready = 0;
    end
    acc = start && !bz && !rs;
    if (acc) begin
      cur_n = int'(fb);
      exp_c = nxt_pix;
      if (fb != 0) for (int i = 0; i < FL; i++) exp_c.push_back(32'h0);
      c_log.delete();
      fr_r_cnt = 0;
      fr_s_cnt = 0;
      m_start  = m_cnt;
      exp_done_cnt++;
      chk_busy_next = 1;
      exp_busy_next = (fb != 0);
    end
    #1;
    if (!rs) begin
      if (r_valid && r_ready) begin
        void'(conv_q.pop_front());
        fr_r_cnt++;
        last_r_cyc = cyc;
      end
      if (c_valid && c_ready) begin
        conv_q.push_back(c_data);
        c_log.push_back(c_data);
      end
      if (s_valid && s_ready) begin
        void'(src_q.pop_front());
        fr_s_cnt++;
      end
    end
  endtask

  task automatic wait_done(input bit auto_st, input logic [15:0] fb, input string nm);
    int n = 0;
    got_done = 0;
    while (!got_done && n < 3000) begin
      tick(0, fb, auto_st, 0);
      n++;
    end
    chk(nm, got_done, 1);
  endtask

  // Monitor: pops the scoreboard on every delivered result beat.
  always begin
    logic [32:0] e;
    @(negedge clk);
    #2;
    if (m_valid && m_ready) begin
      m_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL m_extra_beat: got %0h expected none", m_data);
      end else begin
        e = exp_q.pop_front();
        chk("m_data", m_data, e[31:0]);
        chk("m_last", m_last, e[32]);
      end
    end else if (!m_valid) begin
      chk("m_last_without_valid", m_last, 0);
    end
  end

  initial begin
    int n;
    rst = 1; start = 0; frame_beats = 0;
    s_valid = 0; s_data = 0; c_ready = 0; r_valid = 0; r_data = 0; m_ready = 0;
    reset_conv();
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_c_valid", c_valid, 0);
    chk("rst_c_data", c_data, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_r_ready", r_ready, 1);

    // Basic frame, beats 1..4, no back-pressure.
    rnd = 0;
    begin_frame(4, 1);
    tick(1, 4, 0, 0);
    wait_done(0, 0, "basic_done_seen");
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);

    // Random back-pressure on every interface, N=100.
    rnd = 1;
    begin_frame(100, 0);
    tick(1, 100, 0, 0);
    wait_done(0, 0, "backpressure_done_seen");
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);

    // Zero-length frame.
    begin_frame(0, 0);
    tick(1, 0, 0, 0);
    wait_done(0, 0, "zero_len_done_seen");
    tick(0, 0, 0, 0);
    chk("zero_len_busy_after", busy, 0);

    // Back-to-back: second start issued in the done cycle of the first.
    begin_frame(20, 0);
    tick(1, 20, 0, 0);
    begin_frame(5, 0);
    wait_done(1, 5, "b2b_first_done_seen");
    wait_done(0, 0, "b2b_second_done_seen");

    // Start while busy must be ignored.
    rnd = 0;
    begin_frame(8, 0);
    tick(1, 8, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(1, 3, 0, 0);
    wait_done(0, 0, "busy_start_done_seen");
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);

    // Reset after 3 of 10 beats.
    begin_frame(10, 0);
    tick(1, 10, 0, 0);
    n = 0;
    while (fr_s_cnt < 3 && n < 200) begin
      tick(0, 0, 0, 0);
      n++;
    end
    chk("reset_prefeed_beats", fr_s_cnt, 3);
    tick(0, 0, 0, 1);
    @(posedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_r_ready", r_ready, 1);
    chk("midrst_done", done, 0);
    src_q.delete();
    exp_q.delete();
    reset_conv();
    exp_done_cnt--;
    cur_n = 0;
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    begin_frame(2, 0);
    tick(1, 2, 0, 0);
    wait_done(0, 0, "post_reset_done_seen");

    // A few random-length frames under random back-pressure.
    rnd = 1;
    for (int f = 0; f < 3; f++) begin
      n = $urandom_range(1, 30);
      begin_frame(n, 0);
      tick(1, 16'(n), 0, 0);
      wait_done(0, 0, "random_frame_done_seen");
      tick(0, 0, 0, 0);
    end

    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);
    chk("done_pulse_count", done_cnt, exp_done_cnt);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
